// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// The NOP encoding is what the pipeline registers load on a flush or bubble.
package hazard_pkg;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MDU = 1'b1
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: enables, flushes and bubbles for the
// PC and pipeline registers, with saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT     = 4,
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_mdu,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             exmem_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int MDU_W  = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MDU_W-1:0]  MDU_INIT   = MDU_W'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic              MDU_MULTI  = (MDU_LAT > 1);

    state_t            r_state;
    logic [MDU_W-1:0]  r_mdu_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;

    logic              w_freeze;
    logic              w_mdu_start;
    logic              w_mdu_stall;
    logic              w_load_use;
    logic [WAIT_W-1:0] w_wait_next;

    assign w_freeze    = mem_req & ~mem_ready;
    // The release cycle (S_MDU, count 0) must not start a new stall.
    assign w_mdu_start = (r_state == S_RUN) & ex_is_mdu & MDU_MULTI;
    assign w_mdu_stall = w_mdu_start | ((r_state == S_MDU) & (r_mdu_cnt != '0));
    assign w_load_use  = ex_mem_read & (ex_rd != 5'd0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                          (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign w_wait_next = (r_wait_cnt == WAIT_LIMIT) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            exmem_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (w_mdu_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_mdu_cnt  <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (w_freeze) begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next == WAIT_LIMIT)
                r_mem_err <= 1'b1;
        end else begin
            r_wait_cnt <= '0;
            if (w_mdu_start) begin
                r_mdu_cnt <= MDU_INIT;
                r_state   <= S_MDU;
            end else if (r_state == S_MDU) begin
                if (r_mdu_cnt != '0)
                    r_mdu_cnt <= r_mdu_cnt - 1'b1;
                else
                    r_state <= S_RUN;
            end
        end
    end

    assign mem_err = r_mem_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a combinational hazard table plus hand-written
// MDU, freeze, timeout, async-reset and saturation sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_is_mdu = 0;
    logic       ex_branch_taken = 0, mem_req = 0, mem_ready = 0;

    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, mem_err;
    logic [3:0] stall_cycles, flush_count;
    logic       pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_en1, exmem_bubble1, mem_err1;
    logic [3:0] stall_cycles1, flush_count1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LAT(4), .MEM_TIMEOUT(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_is_mdu(ex_is_mdu), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .exmem_bubble(exmem_bubble), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Single-cycle MDU variant: an MDU op must never stall.
    hazard_ctrl #(.MDU_LAT(1), .MEM_TIMEOUT(8), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_is_mdu(ex_is_mdu), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en1), .ifid_en(ifid_en1),
        .ifid_flush(ifid_flush1), .idex_en(idex_en1), .idex_bubble(idex_bubble1),
        .exmem_en(exmem_en1), .exmem_bubble(exmem_bubble1), .mem_err(mem_err1),
        .stall_cycles(stall_cycles1), .flush_count(flush_count1)
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble}
    logic [6:0] outv, outv1;
    assign outv  = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble};
    assign outv1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_en1, exmem_bubble1};

    localparam logic [6:0] O_RUN   = 7'b1101010;
    localparam logic [6:0] O_LU    = 7'b0001110;
    localparam logic [6:0] O_FLUSH = 7'b1111110;
    localparam logic [6:0] O_FRZ   = 7'b0000000;
    localparam logic [6:0] O_MDU   = 7'b0000011;
    localparam logic [6:0] O_RST   = 7'b0010101;

    typedef struct packed {
        logic       mreq, mrdy, mrd;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_is_mdu = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Inputs change only on the falling edge; checks sit 2ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("reset_outputs", 32'(outv), 32'(O_RST));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_use_inputs();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, O_LU};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, O_RUN};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, O_LU};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, O_RUN};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, O_FLUSH};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, O_FRZ};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, O_RUN};

        do_reset();
        chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("reset_flush_cnt", 32'(flush_count), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);

        // Combinational hazard table, all from S_RUN.
        for (int i = 0; i < 10; i++) begin
            mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy; ex_mem_read = tbl[i].mrd;
            ex_rd = tbl[i].rd; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
            id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2; ex_branch_taken = tbl[i].br;
            #2;
            chk($sformatf("table[%0d]", i), 32'(outv), 32'(tbl[i].exp));
            step();
        end
        clear_inputs();
        #2;
        chk("table_stall_cnt", 32'(stall_cycles), 32'd3);
        chk("table_flush_cnt", 32'(flush_count), 32'd1);

        // MDU_LAT=4: three stall cycles, branch ignored while stalled, then release.
        do_reset();
        ex_is_mdu = 1;
        for (int c = 0; c < 4; c++) begin
            ex_branch_taken = (c == 1);
            #2;
            chk($sformatf("mdu_cyc%0d", c), 32'(outv), 32'((c < 3) ? O_MDU : O_RUN));
            if (c == 0) chk("mdu_lat1_no_stall", 32'(outv1), 32'(O_RUN));
            step();
        end
        clear_inputs();
        #2;
        chk("mdu_stall_cnt", 32'(stall_cycles), 32'd3);
        chk("mdu_branch_ignored", 32'(flush_count), 32'd0);

        // Branch wins over a simultaneous load-use.
        do_reset();
        load_use_inputs();
        ex_branch_taken = 1;
        #2;
        chk("branch_over_lu", 32'(outv), 32'(O_FLUSH));
        step();
        clear_inputs();
        #2;
        chk("branch_flush_cnt", 32'(flush_count), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cycles), 32'd0);

        // Freeze for 5 cycles while mdu_cnt==1; MDU count must hold.
        do_reset();
        ex_is_mdu = 1;
        step();
        step();
        mem_req = 1; mem_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("frz_mdu%0d", c), 32'(outv), 32'(O_FRZ));
            step();
        end
        mem_ready = 1;
        #2;
        chk("frz_mdu_last_stall", 32'(outv), 32'(O_MDU));
        step();
        mem_req = 0; mem_ready = 0;
        #2;
        chk("frz_mdu_release", 32'(outv), 32'(O_RUN));
        step();
        ex_is_mdu = 0;
        #2;
        chk("frz_mdu_stall_cnt", 32'(stall_cycles), 32'd8);

        // Timeout at 8 wait cycles; mem_err is sticky until reset.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            #2;
            if (c == 7 || c == 8 || c == 10)
                chk($sformatf("timeout_after%0d", c), 32'(mem_err), 32'(c >= 8));
        end
        chk("timeout_stall_cnt", 32'(stall_cycles), 32'd10);
        mem_ready = 1;
        step();
        mem_req = 0;
        step();
        #2;
        chk("timeout_sticky", 32'(mem_err), 32'd1);
        do_reset();
        chk("timeout_cleared", 32'(mem_err), 32'd0);

        // Async reset mid-MDU, then counter saturation.
        ex_is_mdu = 1;
        step();
        ex_is_mdu = 0;
        #2;
        chk("mid_mdu_stalling", 32'(outv), 32'(O_MDU));
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(outv), 32'(O_RST));
        #1;
        rst = 1'b0;
        #1;
        chk("after_rst_run", 32'(outv), 32'(O_RUN));
        chk("after_rst_stall_cnt", 32'(stall_cycles), 32'd0);
        step();
        load_use_inputs();
        for (int c = 0; c < 20; c++) step();
        clear_inputs();
        #2;
        chk("stall_saturate", 32'(stall_cycles), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
